// File: rtl/decompress_unpacker_if.sv
// Handshake bundle for decompress_unpacker: packed-line input side and 64-bit beat output side.
interface decompress_unpacker_if #(
  parameter int CACHE_LINE = 128,
  parameter int WIDTH      = 64
) ();
  logic [CACHE_LINE-1:0] i_line;
  logic                  i_raw;
  logic                  i_valid;
  logic                  o_ready;
  logic [WIDTH-1:0]      o_word;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic                  o_err;

  modport slave  (input  i_line, i_raw, i_valid, i_ready,
                  output o_ready, o_word, o_valid, o_last, o_err);
  modport master (output i_line, i_raw, i_valid, i_ready,
                  input  o_ready, o_word, o_valid, o_last, o_err);
endinterface

// File: rtl/decompress_unpacker.sv
// C-Pack style line decompressor: rebuilds four words as two beats with a mirrored FIFO dictionary.
// Optional DECOMP_DICT_CLR_PER_LINE_EN clears the dictionary and write pointer on every line accept.
module decompress_unpacker #(
  parameter int CACHE_LINE = 128,
  parameter int WIDTH      = 64,
  parameter int DICT_ENTRY = 16,
  parameter int DICT_WORD  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  decompress_unpacker_if.slave bus
);
  localparam int IDXW = $clog2(DICT_ENTRY);
  localparam int PAD  = 40;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  typedef logic [DICT_ENTRY-1:0][DICT_WORD-1:0] dict_t;
  typedef struct packed {
    logic [DICT_WORD-1:0] word;
    logic                 push;
    logic                 err;
    logic [5:0]           len;
  } code_t;

  // Zero padding below bit 0 makes reads past the end return zeros.
  function automatic code_t decode_code(input logic [CACHE_LINE-1:0] line,
                                        input logic [7:0] pos, input dict_t view);
    logic [33:0] w;
    code_t       c;
    w = 34'({line, {PAD{1'b0}}} >> ({1'b0, pos} + 9'd7));
    c = '0;
    unique casez (w[33:30])
      4'b00??: c.len = 6'd2;
      4'b01??: begin c.word = w[31:0]; c.push = 1'b1; c.len = 6'd34; end
      4'b10??: begin c.word = view[w[31:28]]; c.len = 6'd6; end
      4'b1100: begin c.word = {view[w[29:26]][31:16], w[25:10]}; c.push = 1'b1; c.len = 6'd24; end
      4'b1101: begin c.word = {24'h0, w[29:22]}; c.len = 6'd12; end
      4'b1110: begin c.word = {view[w[29:26]][31:8], w[25:18]}; c.push = 1'b1; c.len = 6'd16; end
      default: begin c.err = 1'b1; c.len = 6'd4; end
    endcase
    if (({1'b0, pos} + 9'd1) < {3'b000, c.len}) c.err = 1'b1;
    return c;
  endfunction

  state_t                r_state;
  logic [CACHE_LINE-1:0] r_line;
  logic                  r_raw;
  logic [7:0]            r_ptr;
  logic [WIDTH-1:0]      r_word;
  logic [1:0]            r_push;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_err;
  dict_t                 r_dict;
  logic [IDXW-1:0]       r_wp;

  logic                  w_ready, w_accept, w_commit, w_clr;
  dict_t                 w_dict_nx;
  logic [IDXW-1:0]       w_wp_nx;
  logic [CACHE_LINE-1:0] w_src_line;
  logic                  w_src_raw, w_src_hi;
  logic [7:0]            w_src_pos, w_pos1, w_pos_nx;
  code_t                 w_c0, w_c1;
  logic [WIDTH-1:0]      w_dec_word;
  logic [1:0]            w_dec_push;
  logic                  w_dec_err;

  assign w_ready  = (r_state == IDLE) || ((r_state == BEAT1) && bus.i_ready);
  assign w_accept = w_ready && bus.i_valid;
  assign w_commit = r_valid && bus.i_ready;

`ifdef DECOMP_DICT_CLR_PER_LINE_EN
  assign w_clr = w_accept;
`else
  assign w_clr = 1'b0;
`endif

  // The presented beat's pushes are forwarded so the next beat decodes against them.
  always_comb begin
    w_dict_nx = r_dict;
    w_wp_nx   = r_wp;
    if (w_commit) begin
      if (r_push[0]) begin
        w_dict_nx[w_wp_nx] = r_word[DICT_WORD-1:0];
        w_wp_nx            = w_wp_nx + IDXW'(1);
      end
      if (r_push[1]) begin
        w_dict_nx[w_wp_nx] = r_word[WIDTH-1:DICT_WORD];
        w_wp_nx            = w_wp_nx + IDXW'(1);
      end
    end
    if (w_clr) begin
      w_dict_nx = '0;
      w_wp_nx   = '0;
    end
  end

  assign w_src_line = w_accept ? bus.i_line : r_line;
  assign w_src_raw  = w_accept ? bus.i_raw  : r_raw;
  assign w_src_pos  = w_accept ? 8'd127     : r_ptr;
  assign w_src_hi   = !w_accept;

  always_comb begin
    w_c0     = decode_code(w_src_line, w_src_pos, w_dict_nx);
    w_pos1   = w_src_pos - {2'b00, w_c0.len};
    w_c1     = decode_code(w_src_line, w_pos1, w_dict_nx);
    w_pos_nx = w_pos1 - {2'b00, w_c1.len};
    if (w_src_raw) begin
      w_dec_word = w_src_hi ? w_src_line[CACHE_LINE-1:WIDTH] : w_src_line[WIDTH-1:0];
      w_dec_push = 2'b11;
      w_dec_err  = 1'b0;
    end else begin
      w_dec_word = {w_c1.word, w_c0.word};
      w_dec_push = {w_c1.push, w_c0.push};
      w_dec_err  = w_c0.err | w_c1.err;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_raw   <= 1'b0;
      r_ptr   <= 8'd127;
      r_word  <= '0;
      r_push  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_dict  <= '0;
      r_wp    <= '0;
    end else begin
      r_dict <= w_dict_nx;
      r_wp   <= w_wp_nx;
      if (w_accept) begin
        r_state <= BEAT0;
        r_line  <= bus.i_line;
        r_raw   <= bus.i_raw;
        r_ptr   <= w_pos_nx;
        r_word  <= w_dec_word;
        r_push  <= w_dec_push;
        r_err   <= w_dec_err;
        r_valid <= 1'b1;
        r_last  <= 1'b0;
      end else if (w_commit) begin
        case (r_state)
          BEAT0: begin
            r_state <= BEAT1;
            r_ptr   <= w_pos_nx;
            r_word  <= w_dec_word;
            r_push  <= w_dec_push;
            r_err   <= w_dec_err;
            r_last  <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
            r_ptr   <= 8'd127;
            r_push  <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_word  = r_word;
  assign bus.o_valid = r_valid;
  assign bus.o_last  = r_last;
  assign bus.o_err   = r_err;
endmodule

// File: tb/tb_decompress_unpacker.sv
// Directed bench for decompress_unpacker: hand-built code lines with hand-computed beats.
module tb_decompress_unpacker;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  decompress_unpacker_if #(.CACHE_LINE(128), .WIDTH(64)) bus ();

  decompress_unpacker #(
    .CACHE_LINE(128),
    .WIDTH(64),
    .DICT_ENTRY(16),
    .DICT_WORD(32)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] line, input logic raw);
    int unsigned n;
    n = 0;
    bus.i_line  = line;
    bus.i_raw   = raw;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [63:0] exp, input logic last, input logic err);
    check({tag, "_valid"}, {63'd0, bus.o_valid}, 64'd1);
    check({tag, "_word"}, bus.o_word, exp);
    check({tag, "_last"}, {63'd0, bus.o_last}, {63'd0, last});
    check({tag, "_err"}, {63'd0, bus.o_err}, {63'd0, err});
  endtask

  task automatic run_line(input string tag, input logic [127:0] line, input logic raw,
                          input logic [63:0] e0, input logic err0,
                          input logic [63:0] e1, input logic err1);
    send(line, raw);
    beat({tag, "_b0"}, e0, 1'b0, err0);
    @(posedge clk); #1;
    beat({tag, "_b1"}, e1, 1'b1, err1);
    @(posedge clk); #1;
    check({tag, "_idle"}, {62'd0, bus.o_valid, bus.o_err}, 64'd0);
  endtask

  initial begin
    logic [135:0] long_line;
    logic [31:0]  base;

    rst_n       = 1'b0;
    bus.i_line  = '0;
    bus.i_raw   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("rst_word", bus.o_word, 64'd0);
    check("rst_ready", {63'd0, bus.o_ready}, 64'd1);
    check("rst_err", {63'd0, bus.o_err}, 64'd0);
    check("rst_last", {63'd0, bus.o_last}, 64'd0);

    run_line("zero", 128'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);

    // Same-beat push invisible to word1; beat1 sees beat0's push.
    run_line("dep", {2'b01, 32'hDEADBEEF, 6'b10_0000, 4'b1110, 4'h0, 8'h11, 6'b10_0001, 66'd0}, 1'b0,
             64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0000_0000_DEAD_BE11, 1'b0);

    // Reset during beat0 drops the line.
    send({4{32'hAAAA_AAAA}}, 1'b1);
    beat("mid_b0", {2{32'hAAAA_AAAA}}, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, bus.o_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_after_valid", {63'd0, bus.o_valid}, 64'd0);
    check("mid_after_word", bus.o_word, 64'd0);
    check("mid_after_ready", {63'd0, bus.o_ready}, 64'd1);

    // Raw line into a fresh dictionary, then a readback line accepted back-to-back.
    send(128'h4444_4444_3333_3333_2222_2222_1111_1111, 1'b1);
    beat("raw_b0", 64'h2222_2222_1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    beat("raw_b1", 64'h4444_4444_3333_3333, 1'b1, 1'b0);
    bus.i_line  = {6'b10_0011, 6'b10_0010, 6'b10_0001, 6'b10_0000, 104'd0};
    bus.i_raw   = 1'b0;
    bus.i_valid = 1'b1;
    check("b2b_ready", {63'd0, bus.o_ready}, 64'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    beat("rd_b0", 64'h3333_3333_4444_4444, 1'b0, 1'b0);
    @(posedge clk); #1;
    beat("rd_b1", 64'h1111_1111_2222_2222, 1'b1, 1'b0);
    @(posedge clk); #1;

    // 16 raw words plus 2 literals: wp 4 -> 6, entries 0..5 overwritten.
    for (int k = 0; k < 4; k++) begin
      base = 32'hF000_0000 + 32'(4 * k);
      run_line("wrap_raw", {base + 32'd3, base + 32'd2, base + 32'd1, base}, 1'b1,
               {base + 32'd1, base}, 1'b0, {base + 32'd3, base + 32'd2}, 1'b0);
    end
    run_line("wrap_lit", {2'b01, 32'h1234_5678, 2'b01, 32'h9ABC_DEF0, 2'b00, 2'b00, 56'd0}, 1'b0,
             64'h9ABC_DEF0_1234_5678, 1'b0, 64'd0, 1'b0);
    run_line("wrap_rd", {6'b10_0000, 6'b10_0101, 6'b10_0110, 6'b10_1111, 104'd0}, 1'b0,
             64'h9ABC_DEF0_F000_000C, 1'b0, 64'hF000_000B_F000_0002, 1'b0);
    run_line("wrap_wp", {2'b01, 32'hCAFE_F00D, 2'b00, 6'b10_0110, 6'b10_0111, 80'd0}, 1'b0,
             64'h0000_0000_CAFE_F00D, 1'b0, 64'hF000_0003_CAFE_F00D, 1'b0);

    // Four literals overrun bit 0: word3 loses its low 8 bits.
    long_line = {2'b01, 32'h1111_1111, 2'b01, 32'h2222_2222, 2'b01, 32'h3333_3333, 2'b01, 32'h4444_4444};
    run_line("ovr", long_line[135:8], 1'b0,
             64'h2222_2222_1111_1111, 1'b0, 64'h4444_4400_3333_3333, 1'b1);

    run_line("resv", {4'b1111, 2'b01, 32'h7654_3210, 2'b00, 2'b00, 86'd0}, 1'b0,
             64'h7654_3210_0000_0000, 1'b1, 64'd0, 1'b0);

    // Backpressure on beat0 for five cycles.
    bus.i_ready = 1'b0;
    send({2'b01, 32'h1357_9BDF, 2'b00, 6'b10_1100, 6'b10_1011, 80'd0}, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("bp_word", bus.o_word, 64'h0000_0000_1357_9BDF);
      check("bp_ready", {63'd0, bus.o_ready}, 64'd0);
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    beat("bp_b0", 64'h0000_0000_1357_9BDF, 1'b0, 1'b0);
    @(posedge clk); #1;
    beat("bp_b1", 64'h7654_3210_1357_9BDF, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_line("bp_wp", {2'b01, 32'hFEED_FACE, 2'b00, 6'b10_1101, 6'b10_0111, 80'd0}, 1'b0,
             64'h0000_0000_FEED_FACE, 1'b0, 64'h1111_1111_FEED_FACE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
